kronos_boot_loader: RTL and testbench

- Byte-stream program loader that sits between a host serial link (UART receiver) and the Kronos instruction/data memory write port.
- Receives a framed image of 32-bit RV32I instruction words, writes them to memory through a request/ack port, and checks an XOR checksum.
- Holds the core in reset until the load completes cleanly, then releases it.

---
 rtl/kronos_boot_loader.sv | 178 +++++++++++++++++
 tb/tb_kronos_boot_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_boot_loader.sv
// Byte-stream program loader: receives a framed RV32I image
// (ADDR, LEN, DATA[N], CSUM), writes each word through a req/ack memory
// port, verifies an XOR checksum and releases the core from reset on success.
module kronos_boot_loader #(
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic        rx_rdy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic        reload,
    output logic        core_rstz,
    output logic        boot_done,
    output logic        boot_error
);

    localparam int unsigned CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [23:0]   asm_q, asm_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   csum_q, csum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          rdy;
    logic          byte_take;
    logic          last_byte;
    logic [31:0]   word;

    // Byte acceptance: only the receiving states take bytes from the link.
    always_comb begin
        rdy       = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                    (state_q == ST_DATA) || (state_q == ST_CSUM);
        byte_take = rx_vld && rdy;
        last_byte = byte_take && (idx_q == 2'd3);
        // The 4th byte is used directly so the full word is available on its accept cycle.
        word      = {rx_data, asm_q};
    end

    // State register.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) state_q <= ST_ADDR;
        else       state_q <= state_d;
    end

    // Next-state and datapath updates for framing, writing and checksum.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;

        if (byte_take) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    asm_d[7:0]   = rx_data;
                2'd1:    asm_d[15:8]  = rx_data;
                2'd2:    asm_d[23:16] = rx_data;
                default: ;
            endcase
        end

        case (state_q)
            ST_ADDR: begin
                if (last_byte) begin
                    if (word[1:0] != 2'b00) begin
                        state_d = ST_ERROR;
                    end else begin
                        addr_d  = word;
                        state_d = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                if (last_byte) begin
                    if (word > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (word == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        cnt_d   = word[CW-1:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (last_byte) begin
                    wdata_d = word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    csum_d  = csum_q ^ wdata_q;
                    addr_d  = addr_q + 32'd4;
                    cnt_d   = cnt_q - CW'(1);
                    state_d = (cnt_q == CW'(1)) ? ST_CSUM : ST_DATA;
                end
            end
            ST_CSUM: begin
                if (last_byte) begin
                    state_d = (word == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (reload) begin
                    state_d = ST_ADDR;
                    idx_d   = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                    csum_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_ADDR;
        endcase

        // Status flags follow the state being entered, so they appear one cycle after the final byte.
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERROR);
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            idx_q   <= '0;
            asm_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rx_rdy      = rdy;
    assign mem_req     = (state_q == ST_WRITE);
    assign mem_we      = (state_q == ST_WRITE);
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign core_rstz   = done_q;
    assign boot_done   = done_q;
    assign boot_error  = err_q;

endmodule

// File: tb/tb_kronos_boot_loader.sv
// Testbench for kronos_boot_loader: frame builder/reference model,
// byte driver, memory ack responder and a decoupled scoreboard monitor.
module tb_kronos_boot_loader;

    localparam int unsigned MAXW = 4096;

    logic        clk = 1'b0;
    logic        rstz;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        rx_rdy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        reload;
    logic        core_rstz;
    logic        boot_done;
    logic        boot_error;

    kronos_boot_loader #(.MAX_WORDS(MAXW)) dut (
        .clk         (clk),
        .rstz        (rstz),
        .rx_data     (rx_data),
        .rx_vld      (rx_vld),
        .rx_rdy      (rx_rdy),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .reload      (reload),
        .core_rstz   (core_rstz),
        .boot_done   (boot_done),
        .boot_error  (boot_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_wr[$];
    logic [7:0]  exp_b[$];
    logic [31:0] img[$];
    int          ack_delay = 0;
    int          ack_cnt   = 0;
    int          req_len   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay extra cycles of mem_req.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstz || mem_ack) begin
                mem_ack = 1'b0;
                ack_cnt = 0;
            end else if (mem_req) begin
                if (ack_cnt >= ack_delay) mem_ack = 1'b1;
                else ack_cnt++;
            end
        end
    end

    // Monitor: pops expected bytes/writes whenever a handshake is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstz) begin
                req_len = 0;
            end else begin
                if (rx_vld && rx_rdy) begin
                    if (exp_b.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_byte: byte 0x%02h accepted, expected none", rx_data);
                    end else begin
                        chk("rx_byte", {24'h0, rx_data}, {24'h0, exp_b.pop_front()});
                    end
                end
                if (mem_req) begin
                    req_len++;
                    chk("mem_we", {31'h0, mem_we}, 32'h1);
                end
                if (mem_req && mem_ack) begin
                    if (exp_wr.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mem_write: write addr 0x%08h data 0x%08h, expected none",
                                 mem_addr, mem_wr_data);
                    end else begin
                        wr_t w;
                        w = exp_wr.pop_front();
                        chk("mem_addr", mem_addr, w.a);
                        chk("mem_wr_data", mem_wr_data, w.d);
                        chk("mem_req_len", req_len, ack_delay + 1);
                        chk("rx_rdy_in_write", {31'h0, rx_rdy}, 32'h0);
                    end
                    req_len = 0;
                end
            end
        end
    end

    // Present each byte until accepted; optional idle gaps with random reload pulses.
    task automatic send_bytes(input logic [7:0] q[$], input bit use_gaps, output bit ok);
        ok = 1'b1;
        foreach (q[i]) begin
            bit acc;
            int to;
            if (use_gaps) begin
                int g;
                g = $urandom_range(0, 2);
                rx_vld = 1'b0;
                for (int k = 0; k < g; k++) begin
                    reload = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                reload = 1'b0;
            end
            rx_data = q[i];
            rx_vld  = 1'b1;
            exp_b.push_back(q[i]);
            acc = 1'b0;
            to  = 0;
            while (!acc && to < 300) begin
                @(negedge clk);
                acc = rx_rdy;
                @(posedge clk);
                #1;
                to++;
            end
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("FAIL byte_timeout: byte %0d not accepted within 300 cycles", i);
                rx_vld = 1'b0;
                exp_b.delete();
                ok = 1'b0;
                return;
            end
        end
        rx_vld = 1'b0;
    endtask

    function automatic void push_word(inout logic [7:0] q[$], input logic [31:0] w);
        for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
    endfunction

    // Build a frame from img, derive expected writes/outcome from the frame rules, run it.
    task automatic run_frame(input string tag, input logic [31:0] addr, input logic [31:0] n,
                             input bit force_csum, input logic [31:0] csum_val,
                             input int delay, input bit use_gaps);
        logic [7:0]  q[$];
        logic [31:0] sum;
        logic [31:0] sent;
        bit          exp_ok;
        bit          ok;
        sum = 32'h0;
        foreach (img[i]) sum ^= img[i];
        sent = force_csum ? csum_val : sum;
        ack_delay = delay;
        push_word(q, addr);
        if (addr[1:0] != 2'b00) begin
            exp_ok = 1'b0;
        end else begin
            push_word(q, n);
            if (n > MAXW) begin
                exp_ok = 1'b0;
            end else begin
                for (int unsigned i = 0; i < n; i++) begin
                    wr_t w;
                    w.a = addr + 32'(4 * i);
                    w.d = img[i];
                    push_word(q, img[i]);
                    exp_wr.push_back(w);
                end
                push_word(q, sent);
                exp_ok = (sent == sum);
            end
        end
        send_bytes(q, use_gaps, ok);
        chk({tag, " boot_done"},  {31'h0, boot_done},  {31'h0, exp_ok});
        chk({tag, " core_rstz"},  {31'h0, core_rstz},  {31'h0, exp_ok});
        chk({tag, " boot_error"}, {31'h0, boot_error}, {31'h0, !exp_ok});
        chk({tag, " rx_rdy_final"}, {31'h0, rx_rdy}, 32'h0);
        chk({tag, " writes_left"}, exp_wr.size(), 32'h0);
        exp_wr.delete();
        // Bytes offered in DONE/ERROR must not be consumed.
        rx_data = 8'hA5;
        rx_vld  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rx_vld = 1'b0;
        chk({tag, " core_rstz_hold"}, {31'h0, core_rstz}, {31'h0, exp_ok});
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        chk({tag, " reload rx_rdy"},     {31'h0, rx_rdy},     32'h1);
        chk({tag, " reload boot_done"},  {31'h0, boot_done},  32'h0);
        chk({tag, " reload boot_error"}, {31'h0, boot_error}, 32'h0);
        chk({tag, " reload core_rstz"},  {31'h0, core_rstz},  32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        bit         ok;
        rstz    = 1'b0;
        rx_data = 8'h00;
        rx_vld  = 1'b0;
        reload  = 1'b0;
        #3;
        chk("reset rx_rdy",      {31'h0, rx_rdy},     32'h1);
        chk("reset mem_req",     {31'h0, mem_req},    32'h0);
        chk("reset mem_we",      {31'h0, mem_we},     32'h0);
        chk("reset mem_addr",    mem_addr,            32'h0);
        chk("reset mem_wr_data", mem_wr_data,         32'h0);
        chk("reset core_rstz",   {31'h0, core_rstz},  32'h0);
        chk("reset boot_done",   {31'h0, boot_done},  32'h0);
        chk("reset boot_error",  {31'h0, boot_error}, 32'h0);
        @(posedge clk);
        #1;
        rstz = 1'b1;

        img = '{32'h00500093};
        run_frame("single", 32'h0, 32'd1, 1'b0, 32'h0, 0, 1'b0);

        img = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        run_frame("three", 32'h100, 32'd3, 1'b0, 32'h0, 3, 1'b0);
        run_frame("badcsum", 32'h100, 32'd3, 1'b1, 32'h0, 3, 1'b0);

        img = {};
        run_frame("misaligned", 32'h102, 32'd0, 1'b0, 32'h0, 0, 1'b0);
        run_frame("toolong", 32'h0, MAXW + 1, 1'b0, 32'h0, 0, 1'b0);
        run_frame("len0", 32'h40, 32'd0, 1'b0, 32'h0, 0, 1'b0);

        img = '{32'h11111111, 32'h22222222, 32'h44444444};
        run_frame("wrap", 32'hFFFFFFF8, 32'd3, 1'b0, 32'h0, 1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            int unsigned n;
            n = $urandom_range(1, 6);
            img = {};
            for (int unsigned i = 0; i < n; i++) img.push_back($urandom());
            run_frame($sformatf("rand%0d", r), $urandom() & 32'hFFFFFFFC, n,
                      ($urandom_range(0, 3) == 0), $urandom(),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while a write is pending.
        ack_delay = 50;
        q = {};
        push_word(q, 32'h200);
        push_word(q, 32'd2);
        push_word(q, 32'hDEADBEEC);
        send_bytes(q, 1'b0, ok);
        chk("midwrite mem_req_before", {31'h0, mem_req}, 32'h1);
        #2;
        rstz = 1'b0;
        #1;
        chk("midwrite mem_req",     {31'h0, mem_req},   32'h0);
        chk("midwrite mem_we",      {31'h0, mem_we},    32'h0);
        chk("midwrite core_rstz",   {31'h0, core_rstz}, 32'h0);
        chk("midwrite rx_rdy",      {31'h0, rx_rdy},    32'h1);
        chk("midwrite mem_addr",    mem_addr,           32'h0);
        chk("midwrite mem_wr_data", mem_wr_data,        32'h0);
        exp_b.delete();
        exp_wr.delete();
        @(posedge clk);
        #1;
        rstz = 1'b1;
        img = '{32'hCAFEF00D, 32'h0BADC0DE};
        run_frame("after_reset", 32'h300, 32'd2, 1'b0, 32'h0, 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
